// File: rtl/aux_seg_pkg.sv
// Shared constants for the seven-segment scanner: FSM encoding and
// active-low segment patterns ({g,f,e,d,c,b,a}).
package aux_seg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_SHOW  = 2'd2;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/aux_seg_scanner_if.sv
// Display-side bundle for aux_seg_scanner: scan clock, enable, digit data in;
// cathode/anode drive and current digit index out.
interface aux_seg_scanner_if #(
  parameter int Digits = 8
);
  localparam int IdxBit = $clog2(Digits);

  logic                  scan_clk;
  logic                  en;
  logic [4*Digits-1:0]   data;
  logic [Digits-1:0]     dp;
  logic [7:0]            seg_n;
  logic [Digits-1:0]     an_n;
  logic [IdxBit-1:0]     digit_idx;

  modport master (
    output scan_clk, en, data, dp,
    input  seg_n, an_n, digit_idx
  );

  modport slave (
    input  scan_clk, en, data, dp,
    output seg_n, an_n, digit_idx
  );
endinterface

// File: rtl/aux_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module aux_seg_decoder
  import aux_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Pure lookup; unknown codes fall back to all segments off.
  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0:    seg_n = SEG_HEX_0;
      4'h1:    seg_n = SEG_HEX_1;
      4'h2:    seg_n = SEG_HEX_2;
      4'h3:    seg_n = SEG_HEX_3;
      4'h4:    seg_n = SEG_HEX_4;
      4'h5:    seg_n = SEG_HEX_5;
      4'h6:    seg_n = SEG_HEX_6;
      4'h7:    seg_n = SEG_HEX_7;
      4'h8:    seg_n = SEG_HEX_8;
      4'h9:    seg_n = SEG_HEX_9;
      4'hA:    seg_n = SEG_HEX_A;
      4'hB:    seg_n = SEG_HEX_B;
      4'hC:    seg_n = SEG_HEX_C;
      4'hD:    seg_n = SEG_HEX_D;
      4'hE:    seg_n = SEG_HEX_E;
      4'hF:    seg_n = SEG_HEX_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/aux_seg_scanner.sv
// Multiplexed seven-segment scanner stepping one digit per scan_clk rise,
// with a dark gap between digits. Define AUX_SEG_LZB_EN for leading-zero blanking.
module aux_seg_scanner
  import aux_seg_pkg::*;
#(
  parameter int Digits      = 8,
  parameter int BlankCycles = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  aux_seg_scanner_if.slave   bus
);

  localparam int IdxBit = $clog2(Digits);
  localparam int CntBit = (BlankCycles > 1) ? $clog2(BlankCycles) : 1;

  localparam logic [IdxBit-1:0] IDX_LAST = IdxBit'(Digits - 1);
  localparam logic [IdxBit-1:0] IDX_ZERO = {IdxBit{1'b0}};
  localparam logic [CntBit-1:0] CNT_LOAD = CntBit'(BlankCycles - 1);
  localparam logic [CntBit-1:0] CNT_ZERO = {CntBit{1'b0}};
  localparam logic [CntBit-1:0] CNT_ONE  = CntBit'(1);
  localparam logic [Digits-1:0] AN_OFF   = {Digits{1'b1}};
  localparam logic [Digits-1:0] AN_ONE   = Digits'(1);

  logic              scan_s1_r, scan_s2_r, scan_prev_r;
  logic              tick_s;
  state_t            state_r, state_nx_s;
  logic [CntBit-1:0] cnt_r, cnt_nx_s;
  logic [IdxBit-1:0] idx_r, idx_nx_s, idx_inc_s;
  logic [3:0]        nib_s;
  logic [6:0]        pat_s;
  logic [Digits-1:0] show_an_s;
  logic [7:0]        show_seg_s;
  logic [7:0]        seg_n_r;
  logic [Digits-1:0] an_n_r;

  // Two-flop resynchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_s1_r   <= 1'b0;
      scan_s2_r   <= 1'b0;
      scan_prev_r <= 1'b0;
    end else begin
      scan_s1_r   <= bus.scan_clk;
      scan_s2_r   <= scan_s1_r;
      scan_prev_r <= scan_s2_r;
    end
  end

  assign tick_s    = scan_s2_r & ~scan_prev_r;
  assign idx_inc_s = (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IdxBit'(1);

  // Scan sequencing; a low enable overrides everything, including a tick.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    if (!bus.en) begin
      state_nx_s = ST_IDLE;
      cnt_nx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_SHOW: begin
          if (tick_s) begin
            state_nx_s = ST_BLANK;
            cnt_nx_s   = CNT_LOAD;
            idx_nx_s   = idx_inc_s;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_BLANK: begin
          if (cnt_r == CNT_ZERO) begin
            state_nx_s = ST_SHOW;
          end else begin
            cnt_nx_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM, blank counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_LAST;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  assign nib_s = bus.data[4*idx_r +: 4];

  aux_seg_decoder u_dec (
    .nibble (nib_s),
    .seg_n  (pat_s)
  );

`ifdef AUX_SEG_LZB_EN
  logic higher_nz_s;
  logic lz_s;

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    higher_nz_s = 1'b0;
    for (int i = 0; i < Digits; i++) begin
      higher_nz_s = higher_nz_s | ((i >= int'(idx_r)) && (bus.data[4*i +: 4] != 4'h0));
    end
    lz_s = (idx_r != IDX_ZERO) && !higher_nz_s;
  end

  // Drive for the digit about to be lit; a blanked digit keeps only its dp.
  always_comb begin
    show_an_s  = AN_OFF;
    show_seg_s = SEG_OFF;
    if (lz_s && !bus.dp[idx_r]) begin
      show_an_s = AN_OFF;
    end else begin
      show_an_s = ~(AN_ONE << idx_r);
    end
    if (lz_s) begin
      show_seg_s = {~bus.dp[idx_r], SEG_BLANK};
    end else begin
      show_seg_s = {~bus.dp[idx_r], pat_s};
    end
  end
`else
  // Drive for the digit about to be lit.
  always_comb begin
    show_an_s  = ~(AN_ONE << idx_r);
    show_seg_s = {~bus.dp[idx_r], pat_s};
  end
`endif

  // Pins follow the next state; digit content is latched only on entry to SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_r <= SEG_OFF;
      an_n_r  <= AN_OFF;
    end else if (state_nx_s == ST_SHOW) begin
      if (state_r == ST_BLANK) begin
        seg_n_r <= show_seg_s;
        an_n_r  <= show_an_s;
      end else begin
        seg_n_r <= seg_n_r;
        an_n_r  <= an_n_r;
      end
    end else begin
      seg_n_r <= SEG_OFF;
      an_n_r  <= AN_OFF;
    end
  end

  assign bus.seg_n     = seg_n_r;
  assign bus.an_n      = an_n_r;
  assign bus.digit_idx = idx_r;

endmodule
